div_arb_seq: RTL and testbench

Sequencer and two-port arbiter for the team's shift-subtract divider datapath. Accepts division requests from two requesters, grants one at a time (round-robin), and performs a restoring WIDTH-bit unsigned division one quotient bit per clock. Returns quotient, remainder, divide-by-zero flag and requester ID with a one-cycle done pulse. Sits between the requesting blocks and the shared subtract/compare stage, owning all sequencing of that stage.

---
 rtl/div_arb_seq_if.sv | 28 ++
 rtl/div_arb_seq.sv | 141 ++++++++++++++
 tb/tb_div_arb_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_arb_seq_if.sv
// Bus between the two requesters and the divider sequencer.
// The master side drives requests and operands. The slave side returns grants and results.
interface div_arb_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] dvd0;
  logic [WIDTH-1:0] dvs0;
  logic [WIDTH-1:0] dvd1;
  logic [WIDTH-1:0] dvs1;
  logic [1:0]       grant;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (
    output req, dvd0, dvs0, dvd1, dvs1,
    input  grant, busy, done, done_id, q, r, dz
  );

  modport slave (
    input  req, dvd0, dvs0, dvd1, dvs1,
    output grant, busy, done, done_id, q, r, dz
  );
endinterface

// File: rtl/div_arb_seq.sv
// Round-robin two-port arbiter and sequencer for a restoring unsigned divider.
// The divider produces one quotient bit per clock.
module div_arb_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  div_arb_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [WIDTH-1:0] qs_q, qs_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [1:0]       grant_q, grant_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             done_id_q, done_id_d;

  logic             win;
  logic [WIDTH-1:0] dvd_sel;
  logic [WIDTH-1:0] dvs_sel;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH:0]   step_pr;
  logic [WIDTH-1:0] step_qs;
  logic             last;

  // On a tie, the requester that was not served last wins. On a single request, that requester wins.
  always_comb begin
    win     = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];
    dvd_sel = win ? bus.dvd1 : bus.dvd0;
    dvs_sel = win ? bus.dvs1 : bus.dvs0;
    trial   = {pr_q[WIDTH-1:0], qs_q[WIDTH-1]};
    ge      = (trial >= {1'b0, dv_q});
    step_pr = ge ? (trial - {1'b0, dv_q}) : trial;
    step_qs = {qs_q[WIDTH-2:0], ge};
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|bus.req) state_d = (dvs_sel == '0) ? FIN : RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == FIN);
  end

  always_comb begin
    pr_d      = pr_q;
    qs_d      = qs_q;
    dv_d      = dv_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    grant_d   = '0;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    done_id_d = done_id_q;
    if (state_q == IDLE && |bus.req) begin
      qs_d    = dvd_sel;
      dv_d    = dvs_sel;
      pr_d    = '0;
      cnt_d   = '0;
      grant_d = win ? 2'b10 : 2'b01;
      id_d    = win;
      ptr_d   = win;
      // A zero divisor skips RUN, so its results are loaded here, alongside the grant.
      if (dvs_sel == '0) begin
        q_d       = '1;
        r_d       = dvd_sel;
        dz_d      = 1'b1;
        done_id_d = win;
      end
    end else if (state_q == RUN) begin
      pr_d  = step_pr;
      qs_d  = step_qs;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        q_d       = step_qs;
        r_d       = step_pr[WIDTH-1:0];
        dz_d      = 1'b0;
        done_id_d = id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q      <= '0;
      qs_q      <= '0;
      dv_q      <= '0;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;
      id_q      <= 1'b0;
      grant_q   <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      pr_q      <= pr_d;
      qs_q      <= qs_d;
      dv_q      <= dv_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.q       = q_q;
  assign bus.r       = r_q;
  assign bus.dz      = dz_q;
  assign bus.done_id = done_id_q;
endmodule

// File: tb/tb_div_arb_seq.sv
// Randomized and directed bench for div_arb_seq.
// Results are compared against an arithmetic divide model and a last-served arbitration model.
module tb_div_arb_seq;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_id = 1;

  always #5 clk = ~clk;

  div_arb_seq_if #(.WIDTH(W)) bus ();

  div_arb_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},   32'(bus.grant),   0);
    chk({tag, "_busy"},    32'(bus.busy),    0);
    chk({tag, "_done"},    32'(bus.done),    0);
    chk({tag, "_done_id"}, 32'(bus.done_id), 0);
    chk({tag, "_q"},       32'(bus.q),       0);
    chk({tag, "_r"},       32'(bus.r),       0);
    chk({tag, "_dz"},      32'(bus.dz),      0);
  endtask

  // Entered just after a clock edge with the DUT in IDLE. Returns after the FIN->IDLE edge.
  task automatic run_op(input logic [1:0] reqv, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1);
    int w;
    int a, b, eq, er, edz;
    w = (reqv == 2'b11) ? (last_id == 0 ? 1 : 0) : (reqv == 2'b10 ? 1 : 0);
    a = (w == 1) ? int'(a1) : int'(a0);
    b = (w == 1) ? int'(b1) : int'(b0);
    if (b == 0) begin eq = (1 << W) - 1; er = a; edz = 1; end
    else        begin eq = a / b;        er = a % b; edz = 0; end
    bus.req = reqv; bus.dvd0 = a0; bus.dvs0 = b0; bus.dvd1 = a1; bus.dvs1 = b1;
    @(posedge clk); #1;
    chk("grant", 32'(bus.grant), (w == 1) ? 2 : 1);
    chk("busy_accept", 32'(bus.busy), 1);
    last_id = w;
    bus.req  = reqv & ((w == 1) ? 2'b01 : 2'b10);
    bus.dvd0 = W'($urandom); bus.dvs0 = W'($urandom);
    bus.dvd1 = W'($urandom); bus.dvs1 = W'($urandom);
    if (edz == 0) begin
      chk("done_at_grant", 32'(bus.done), 0);
      for (int unsigned k = 1; k <= W; k++) begin
        @(posedge clk); #1;
        chk("grant_run", 32'(bus.grant), 0);
        chk("busy_run", 32'(bus.busy), 1);
        if (k < W) chk("done_early", 32'(bus.done), 0);
      end
    end
    chk("done", 32'(bus.done), 1);
    chk("q", 32'(bus.q), 32'(eq));
    chk("r", 32'(bus.r), 32'(er));
    chk("dz", 32'(bus.dz), 32'(edz));
    chk("done_id", 32'(bus.done_id), 32'(w));
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done), 0);
    chk("busy_after", 32'(bus.busy), 0);
    chk("grant_after", 32'(bus.grant), 0);
    chk("q_hold", 32'(bus.q), 32'(eq));
  endtask

  initial begin
    bus.req = '0; bus.dvd0 = '0; bus.dvs0 = '0; bus.dvd1 = '0; bus.dvs1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // Reset takes priority over a simultaneous request.
    bus.req = 2'b01; bus.dvd0 = 4'd5; bus.dvs0 = 4'd1;
    @(posedge clk); #1;
    chk("rst_req_grant", 32'(bus.grant), 0);
    chk("rst_req_busy", 32'(bus.busy), 0);
    rst = 1'b0; bus.req = '0;
    @(posedge clk); #1;

    run_op(2'b01, 4'd14, 4'd3, 4'd0, 4'd0);
    run_op(2'b01, 4'd15, 4'd15, 4'd0, 4'd0);
    run_op(2'b01, 4'd3, 4'd14, 4'd0, 4'd0);
    run_op(2'b10, 4'd0, 4'd0, 4'd15, 4'd1);
    run_op(2'b10, 4'd0, 4'd0, 4'd0, 4'd5);
    run_op(2'b01, 4'd9, 4'd0, 4'd0, 4'd0);
    run_op(2'b01, 4'd7, 4'd2, 4'd0, 4'd0);

    for (int i = 0; i < 4; i++)
      run_op(2'b11, 4'd13, 4'd4, 4'd11, 4'd3);

    // Abort mid-operation. The pointer should return to 1, so port 0 wins the following tie.
    bus.req = 2'b10; bus.dvd1 = 4'd12; bus.dvs1 = 4'd5;
    @(posedge clk); #1;
    chk("abort_grant", 32'(bus.grant), 2);
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("abort");
    last_id = 1;
    run_op(2'b11, 4'd7, 4'd2, 4'd9, 4'd4);

    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 256; i++) begin
        logic [7:0] pr;
        pr = 8'(i);
        if (p == 0) run_op(2'b01, pr[7:4], pr[3:0], W'($urandom), W'($urandom));
        else        run_op(2'b10, W'($urandom), W'($urandom), pr[7:4], pr[3:0]);
      end

    for (int i = 0; i < 200; i++)
      run_op(2'($urandom_range(1, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
